// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite register-file slave.
// Holds the response codes, the byte-to-word address shift and the
// state encodings of the independent write and read channel FSMs.
package axi4lite_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_COMMIT = 2'b01,
        WR_RESP   = 2'b10
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// NUM_REGS x DATA_WIDTH register storage.
// Ports: clk/rst (synchronous active-high reset clears every register),
//        one byte-enabled write port (we, widx, wdata, wstrb) and one
//        combinational read port (ridx -> rdata).
// The read port shows the stored value before any write landing on the
// same edge, which gives read-before-write ordering at the top level.
module axi4lite_regfile
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];

    // Register storage: clear on reset, byte-merge on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    mem_r[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS read/write 32-bit registers.
// Ports: ACLK/ARESET (synchronous, active-high), write address (AW*),
//        write data (W*), write response (B*), read address (AR*) and
//        read data (R*) channels. All outputs come straight from flops.
// Write and read channels are separate FSMs and never stall each other.
// Misaligned or out-of-range addresses get SLVERR; writes to them are
// dropped and reads of them return zero.
module axi4lite_slave_regfile
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    // Word aligned and inside the register bank.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

    // Write channel state
    wr_state_t                 wr_state_r, wr_state_n;
    logic                      aw_held_r, aw_held_n;
    logic                      w_held_r, w_held_n;
    logic [ADDR_WIDTH-1:0]     awaddr_r, awaddr_n;
    logic [DATA_WIDTH-1:0]     wdata_r, wdata_n;
    logic [DATA_WIDTH/8-1:0]   wstrb_r, wstrb_n;
    logic                      awready_r, awready_n;
    logic                      wready_r, wready_n;
    logic                      bvalid_r, bvalid_n;
    logic [1:0]                bresp_r, bresp_n;
    logic                      reg_we_s;
    logic                      wr_ok_s;

    // Read channel state
    rd_state_t                 rd_state_r, rd_state_n;
    logic                      arready_r, arready_n;
    logic                      rvalid_r, rvalid_n;
    logic [DATA_WIDTH-1:0]     rdata_r, rdata_n;
    logic [1:0]                rresp_r, rresp_n;
    logic [DATA_WIDTH-1:0]     reg_rdata_s;
    logic                      rd_ok_s;

    assign wr_ok_s = addr_ok(awaddr_r);
    assign rd_ok_s = addr_ok(ARADDR);

    axi4lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (reg_we_s),
        .widx  (awaddr_r[ADDR_LSB +: IDX_W]),
        .wdata (wdata_r),
        .wstrb (wstrb_r),
        .ridx  (ARADDR[ADDR_LSB +: IDX_W]),
        .rdata (reg_rdata_s)
    );

    // Write channel registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_r <= WR_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awaddr_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wstrb_r    <= {(DATA_WIDTH/8){1'b0}};
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
        end else begin
            wr_state_r <= wr_state_n;
            aw_held_r  <= aw_held_n;
            w_held_r   <= w_held_n;
            awaddr_r   <= awaddr_n;
            wdata_r    <= wdata_n;
            wstrb_r    <= wstrb_n;
            awready_r  <= awready_n;
            wready_r   <= wready_n;
            bvalid_r   <= bvalid_n;
            bresp_r    <= bresp_n;
        end
    end

    // Write channel next-state: capture AW/W independently, commit, respond.
    always_comb begin
        wr_state_n = wr_state_r;
        aw_held_n  = aw_held_r;
        w_held_n   = w_held_r;
        awaddr_n   = awaddr_r;
        wdata_n    = wdata_r;
        wstrb_n    = wstrb_r;
        awready_n  = awready_r;
        wready_n   = wready_r;
        bvalid_n   = bvalid_r;
        bresp_n    = bresp_r;
        reg_we_s   = 1'b0;
        case (wr_state_r)
            WR_IDLE: begin
                if (AWVALID && awready_r) begin
                    aw_held_n = 1'b1;
                    awaddr_n  = AWADDR;
                end else begin
                    aw_held_n = aw_held_r;
                end
                if (WVALID && wready_r) begin
                    w_held_n = 1'b1;
                    wdata_n  = WDATA;
                    wstrb_n  = WSTRB;
                end else begin
                    w_held_n = w_held_r;
                end
                // READY is low exactly while that channel is held, so it
                // also rises on the first edge out of reset.
                awready_n = !aw_held_n;
                wready_n  = !w_held_n;
                if (aw_held_n && w_held_n) begin
                    wr_state_n = WR_COMMIT;
                end else begin
                    wr_state_n = WR_IDLE;
                end
            end
            WR_COMMIT: begin
                reg_we_s   = wr_ok_s;
                bvalid_n   = 1'b1;
                bresp_n    = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                wr_state_n = WR_RESP;
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_n   = 1'b0;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    wr_state_n = WR_IDLE;
                end else begin
                    bvalid_n   = 1'b1;
                    wr_state_n = WR_RESP;
                end
            end
            default: begin
                aw_held_n  = 1'b0;
                w_held_n   = 1'b0;
                awready_n  = 1'b0;
                wready_n   = 1'b0;
                bvalid_n   = 1'b0;
                wr_state_n = WR_IDLE;
            end
        endcase
    end

    // Read channel registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {DATA_WIDTH{1'b0}};
            rresp_r    <= 2'b00;
        end else begin
            rd_state_r <= rd_state_n;
            arready_r  <= arready_n;
            rvalid_r   <= rvalid_n;
            rdata_r    <= rdata_n;
            rresp_r    <= rresp_n;
        end
    end

    // Read channel next-state: sample the register on AR handshake, hold until R handshake.
    always_comb begin
        rd_state_n = rd_state_r;
        arready_n  = arready_r;
        rvalid_n   = rvalid_r;
        rdata_n    = rdata_r;
        rresp_n    = rresp_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (ARVALID && arready_r) begin
                    rdata_n    = rd_ok_s ? reg_rdata_s : {DATA_WIDTH{1'b0}};
                    rresp_n    = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
                    rvalid_n   = 1'b1;
                    arready_n  = 1'b0;
                    rd_state_n = RD_RESP;
                end else begin
                    arready_n  = 1'b1;
                    rd_state_n = RD_IDLE;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                    rd_state_n = RD_IDLE;
                end else begin
                    rvalid_n   = 1'b1;
                    rd_state_n = RD_RESP;
                end
            end
            default: begin
                rvalid_n   = 1'b0;
                arready_n  = 1'b0;
                rd_state_n = RD_IDLE;
            end
        endcase
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Self-checking bench for axi4lite_slave_regfile: directed scenarios plus
// randomized traffic compared against an array model of the register bank.
module tb_axi4lite_slave_regfile;

    localparam int NREG = 8;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] AWADDR = 32'h0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = 32'h0;
    logic [3:0]  WSTRB = 4'h0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = 32'h0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [NREG];

    axi4lite_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NREG)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference rules computed from the address map, not from the RTL.
    function automatic bit addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a < NREG * 4);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return addr_valid(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return addr_valid(a) ? model[a / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (addr_valid(a)) begin
            v = model[a / 4];
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
            end
            model[a / 4] = v;
        end
    endtask

    // Full write transaction with BREADY high; returns the observed BRESP.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            tick(); n++;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin WVALID = 1'b0;  w_done = 1'b1;  end
        end
        n = 0;
        while (!BVALID && n < 50) begin tick(); n++; end
        resp = BRESP;
        checks++;
        if (!BVALID) begin
            failures++;
            $display("FAIL write_timeout addr=%h observed BVALID=0 required 1", a);
        end
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    endtask

    // Full read transaction with RREADY high; returns observed RDATA/RRESP.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1; n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin tick(); n++; end
        d = RDATA; resp = RRESP;
        checks++;
        if (!RVALID) begin
            failures++;
            $display("FAIL read_timeout addr=%h observed RVALID=0 required 1", a);
        end
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        ARESET = 1'b1;
        tick(); tick();
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs observed=%b required=00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        ARESET = 1'b0;
        tick();
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_ready observed=%b required=111", {AWREADY, WREADY, ARREADY});
        end
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        do_read(32'h0, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin
            failures++;
            $display("FAIL reset_read0 observed=%h/%b required=00000000/00", d, r);
        end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] d; logic [1:0] r;
        AWADDR = 32'h8; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
            failures++;
            $display("FAIL same_cycle_e0 observed AWREADY,WREADY,BVALID=%b required=000", {AWREADY, WREADY, BVALID});
        end
        tick();
        checks++;
        if ({BVALID, BRESP} !== 3'b100) begin
            failures++;
            $display("FAIL same_cycle_bresp observed=%b required=100", {BVALID, BRESP});
        end
        tick();
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            failures++;
            $display("FAIL same_cycle_b_done observed=%b required=011", {BVALID, AWREADY, WREADY});
        end
        BREADY = 1'b0;
        model_write(32'h8, 32'hDEADBEEF, 4'hF);
        do_read(32'h8, d, r);
        checks++;
        if ({d, r} !== {exp_read(32'h8), 2'b00}) begin
            failures++;
            $display("FAIL same_cycle_read observed=%h/%b required=%h/00", d, r, exp_read(32'h8));
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r;
        WDATA = 32'h1234ABCD; WSTRB = 4'h3; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        checks++;
        if (WREADY !== 1'b0) begin
            failures++;
            $display("FAIL w_first_wready observed=%b required=0", WREADY);
        end
        tick(); tick();
        checks++;
        if ({BVALID, AWREADY} !== 2'b01) begin
            failures++;
            $display("FAIL w_first_no_commit observed BVALID,AWREADY=%b required=01", {BVALID, AWREADY});
        end
        AWADDR = 32'h8; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick();
        checks++;
        if ({BVALID, BRESP} !== 3'b100) begin
            failures++;
            $display("FAIL w_first_bresp observed=%b required=100", {BVALID, BRESP});
        end
        tick();
        BREADY = 1'b0;
        model_write(32'h8, 32'h1234ABCD, 4'h3);
        do_read(32'h8, d, r);
        checks++;
        if ({d, r} !== {exp_read(32'h8), 2'b00}) begin
            failures++;
            $display("FAIL w_first_read observed=%h/%b required=%h/00", d, r, exp_read(32'h8));
        end
    endtask

    task automatic test_invalid();
        logic [31:0] d; logic [1:0] r;
        do_write(32'h20, 32'h55, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            failures++;
            $display("FAIL invalid_bresp observed=%b required=10", r);
        end
        do_read(32'h20, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            failures++;
            $display("FAIL invalid_read20 observed=%h/%b required=00000000/10", d, r);
        end
        do_read(32'h6, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            failures++;
            $display("FAIL misaligned_read6 observed=%h/%b required=00000000/10", d, r);
        end
        for (int i = 0; i < NREG; i++) begin
            do_read(32'(i * 4), d, r);
            checks++;
            if ({d, r} !== {model[i], 2'b00}) begin
                failures++;
                $display("FAIL invalid_no_change reg=%0d observed=%h/%b required=%h/00", i, d, r, model[i]);
            end
        end
    endtask

    task automatic test_bready_stall();
        logic [31:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        AWADDR = 32'h8; WDATA = d1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        model_write(32'h8, d1, 4'hF);
        checks++;
        if ({BVALID, BRESP} !== 3'b100) begin
            failures++;
            $display("FAIL stall_bvalid_start observed=%b required=100", {BVALID, BRESP});
        end
        ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b1;
        AWADDR = 32'h4; WDATA = d2; AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d observed=%b required=10000", i, {BVALID, BRESP, AWREADY, WREADY});
            end
            if (i == 0) begin
                ARVALID = 1'b0;
                checks++;
                if ({RVALID, RDATA, RRESP} !== {1'b1, model[2], 2'b00}) begin
                    failures++;
                    $display("FAIL stall_read observed=%b/%h/%b required=1/%h/00", RVALID, RDATA, RRESP, model[2]);
                end
            end
            if (i == 1) begin
                checks++;
                if (RVALID !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_read_done observed RVALID=%b required=0", RVALID);
                end
            end
        end
        RREADY = 1'b0;
        BREADY = 1'b1;
        tick();
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            failures++;
            $display("FAIL stall_b_handshake observed=%b required=011", {BVALID, AWREADY, WREADY});
        end
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if ({AWREADY, WREADY} !== 2'b00) begin
            failures++;
            $display("FAIL stall_next_accept observed=%b required=00", {AWREADY, WREADY});
        end
        tick();
        checks++;
        if ({BVALID, BRESP} !== 3'b100) begin
            failures++;
            $display("FAIL stall_second_bresp observed=%b required=100", {BVALID, BRESP});
        end
        tick();
        BREADY = 1'b0;
        model_write(32'h4, d2, 4'hF);
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r;
        int sel;
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < NREG) a = 32'(sel * 4);
            else if (sel == 8) a = 32'(NREG * 4 + 4 * $urandom_range(0, 3));
            else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, r);
                checks++;
                if (r !== exp_resp(a)) begin
                    failures++;
                    $display("FAIL rand_write addr=%h observed=%b required=%b", a, r, exp_resp(a));
                end
                model_write(a, d, s);
            end else begin
                do_read(a, rd, r);
                checks++;
                if ({rd, r} !== {exp_read(a), exp_resp(a)}) begin
                    failures++;
                    $display("FAIL rand_read addr=%h observed=%h/%b required=%h/%b", a, rd, r, exp_read(a), exp_resp(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r;
        AWADDR = 32'hC; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        tick();
        checks++;
        if ({BVALID, RVALID} !== 2'b11) begin
            failures++;
            $display("FAIL mid_reset_setup observed BVALID,RVALID=%b required=11", {BVALID, RVALID});
        end
        ARESET = 1'b1;
        tick();
        checks++;
        if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00000) begin
            failures++;
            $display("FAIL mid_reset_drop observed=%b required=00000", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
        end
        ARESET = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({BVALID, RVALID} !== 2'b00) begin
                failures++;
                $display("FAIL mid_reset_stale cycle=%0d observed=%b required=00", i, {BVALID, RVALID});
            end
        end
        BREADY = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        for (int i = 0; i < NREG; i++) begin
            do_read(32'(i * 4), d, r);
            checks++;
            if ({d, r} !== {32'h0, 2'b00}) begin
                failures++;
                $display("FAIL mid_reset_clear reg=%0d observed=%h/%b required=00000000/00", i, d, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_invalid();
        test_bready_stall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
AXI4-Lite slave: the DUT the team's bench drives, with a bank of NUM_REGS 32-bit read/write registers. It takes write (AW/W/B) and read (AR/R) transactions from the bench driver, and the bench monitor/checker observe it. Write and read channels run as independent FSMs. Out-of-range and misaligned accesses return SLVERR.

Parameters:
DATA_WIDTH, 32, data bus width (fixed 32; WSTRB is DATA_WIDTH/8)
ADDR_WIDTH, 32, address bus width
NUM_REGS, 8, register count; valid byte addresses are 0 .. NUM_REGS*4-4, word aligned

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  synchronous, active-high reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready

Behaviour:
- Reset (ARESET high at an edge): all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID all 0; BRESP, RRESP, RDATA all 0; FSMs to IDLE; internal held flags cleared. The READYs go to 1 at the first edge with ARESET low.
- Reset mid-transaction: the pending transaction is dropped silently and no response is issued.
- All outputs are registered. Handshake = VALID && READY sampled at a rising edge.
- Decode: the access is valid iff addr[1:0]==0 and addr < NUM_REGS*4. The register index is addr[ADDR_LSB +: $clog2(NUM_REGS)].
- Responses: OKAY = 2'b00; SLVERR = 2'b10 for invalid addresses.
- Write FSM, states WR_IDLE, WR_COMMIT, WR_RESP:
  - WR_IDLE: AW and W are captured independently, in either order or in the same cycle. Each READY drops at the edge that captures its channel. A second AW is not accepted while an AW is held; likewise for W.
  - Once both AW and W are held: go to WR_COMMIT.
  - WR_COMMIT (one cycle): at the next edge, if the address is valid, byte i of the register is updated iff WSTRB[i]; an invalid address writes nothing. At the same edge BRESP is set, BVALID=1, and the FSM goes to WR_RESP.
  - WR_RESP: BVALID and BRESP hold stable until BREADY. At the B handshake edge BVALID=0, held flags clear, AWREADY=WREADY=1, and the FSM returns to WR_IDLE.
  - Minimum latency: AW+W handshake edge E0, commit/BVALID at E1.
- Read FSM, states RD_IDLE, RD_RESP:
  - RD_IDLE: ARREADY=1. At the AR handshake edge: RDATA = register value (0 if invalid), RRESP set, RVALID=1, ARREADY=0, go to RD_RESP.
  - RD_RESP: RDATA, RRESP and RVALID hold until RREADY. At the handshake edge RVALID=0, ARREADY=1, go to RD_IDLE. Maximum throughput is one read per 2 cycles.
- Simultaneous events:
  - A read handshake on the same edge as a write commit to the same register returns the pre-write value.
  - Read and write channels never stall each other.
  - WSTRB=0 on a valid address gives OKAY with no change.

Decomposition:
- Package axi4lite_pkg holds:
  - RESP_OKAY and RESP_SLVERR constants, ADDR_LSB=2;
  - enums wr_state_t {WR_IDLE, WR_COMMIT, WR_RESP} and rd_state_t {RD_IDLE, RD_RESP}.
- Sub-module axi4lite_regfile: NUM_REGS x 32 storage with synchronous reset, one byte-enabled write port and one combinational read port. The top level holds the channel FSMs and the address decode.

Test Plan:
1. Hold ARESET for 2 cycles -> all VALIDs 0 and READYs 0 during reset; READYs 1 one cycle after release. Read 0x0 -> RDATA 0x0, RRESP 00.
2. AW=0x8 and W=0xDEADBEEF, WSTRB 0xF, in the same cycle with BREADY=1 -> BVALID one edge after the handshake, BRESP 00. Then read 0x8 -> 0xDEADBEEF, RRESP 00.
3. W=0x1234ABCD, WSTRB 0x3, presented 3 cycles before AW=0x8 -> WREADY drops after capture, commit occurs only after AW. Read 0x8 -> 0xDEADABCD.
4. Write 0x55 to 0x20 -> BRESP 10 and no register changes. Read 0x20 -> RDATA 0, RRESP 10. Read 0x6 -> RRESP 10.
5. Hold BREADY=0 for 5 cycles after the commit -> BVALID and BRESP stable, AWREADY/WREADY stay 0, and a new AWVALID is not accepted until the edge after the B handshake. Meanwhile a read of 0x8 completes normally.
6. Assert ARESET while in WR_RESP and RD_RESP -> BVALID=RVALID=0 at that edge, all registers read 0 afterwards, and no stale response appears.
